piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter SIZE, default 4: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = word MSB leaves first, 0 = LSB leaves first.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  SIZE  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block can accept din this cycle; combinational.
REQ-008 SO  output  1  serial data out, registered.
REQ-009 sof  output  1  high while SO carries the first bit of a word.
REQ-010 last  output  1  high while SO carries the final bit of a word.
REQ-011 busy  output  1  high while a word is being shifted out.

Function
REQ-012 Two states SHALL exist: IDLE and SHIFT.
REQ-013 A transfer SHALL occur on a rising edge where din_valid and din_ready are both 1.
REQ-014 On transfer, din SHALL load the shift register, the bit counter SHALL load SIZE-1, and the state SHALL become SHIFT.
REQ-015 The first bit of an accepted word SHALL appear on SO exactly one cycle after the transfer edge (latency 1).
REQ-016 In SHIFT, SO SHALL present one bit per cycle for exactly SIZE consecutive cycles, in the order set by MSB_FIRST.
REQ-017 In SHIFT with counter != 0, each edge SHALL shift the register one position and decrement the counter.
REQ-018 sof SHALL equal (state==SHIFT && counter==SIZE-1).
REQ-019 last SHALL equal (state==SHIFT && counter==0).
REQ-020 busy SHALL equal (state==SHIFT).
REQ-021 din_ready SHALL equal !rst && (state==IDLE || last).
REQ-022 In SHIFT with counter==0, a transfer on that edge SHALL load the next word with no idle cycle between words.
REQ-023 In SHIFT with counter==0 and no transfer, the state SHALL return to IDLE.
REQ-024 In IDLE, SO SHALL be 0.
REQ-025 din_valid while din_ready=0 SHALL be ignored; the frame in progress SHALL be unaffected.
REQ-026 din SHALL be sampled only on the transfer edge; later changes to din SHALL have no effect.
REQ-027 The counter width SHALL be $clog2(SIZE) bits; the counter SHALL never wrap below 0.

Reset
REQ-028 While rst=1 at an edge: state SHALL go to IDLE, and the shift register and counter SHALL go to 0.
REQ-029 After that reset edge, the outputs SHALL be SO=0, sof=0, last=0, busy=0; din_ready SHALL be 0 while rst=1.
REQ-030 rst asserted mid-frame SHALL abort the word with no last pulse; the partial word SHALL NOT be resumed.
REQ-031 rst SHALL take priority over a simultaneous transfer.

Structure
REQ-032 The shared package serial_pkg SHALL hold the state encoding localparams (IDLE=0, SHIFT=1) and the default SIZE.
REQ-033 The design SHALL be a single module with no sub-modules: one state register, one shift register, one counter, and combinational output decode.

Verification (SIZE=4)
REQ-034 Reset test: hold rst=1 for 2 cycles -> SO=0, busy=0, din_ready=0; after rst is released, din_ready=1 while idle.
REQ-035 Single word, MSB_FIRST=1: din=4'b1011 transferred at edge N -> SO=1,0,1,1 in cycles N+1..N+4; sof in N+1, last in N+4; busy=0 and SO=0 in N+5.
REQ-036 Back-to-back: 4'b1011 then 4'b0110 with din_valid held -> SO=1,0,1,1,0,1,1,0 with no gap; din_ready high only in idle and last cycles.
REQ-037 LSB-first: MSB_FIRST=0, din=4'b1011 -> SO=1,1,0,1.
REQ-038 Mid-frame events: din_valid pulsed with 4'b0000 in the 2nd bit cycle -> frame unchanged; rst asserted after 2 bits -> next cycle SO=0, busy=0, no last pulse.

Source files
------------

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial blocks.
//   DEFAULT_SIZE : default parallel word width
//   IDLE / SHIFT : state encoding values
//   state_t      : FSM state type built on that encoding
// ---------------------------------------------------------------------------
package serial_pkg;

   localparam int DEFAULT_SIZE = 4;

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   typedef enum logic {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT
   } state_t;

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out shifter with a valid/ready word input.
//
// Parameters
//   SIZE      : word width, 2..32
//   MSB_FIRST : 1 = bit SIZE-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   din       in   parallel word
//   din_valid in   din holds a word offered for transfer
//   din_ready out  word can be accepted this cycle (combinational)
//   SO        out  serial data, straight from the shift register
//   sof       out  SO carries the first bit of a word
//   last      out  SO carries the final bit of a word
//   busy      out  a word is being shifted out
//
// Handshake: a word moves on a rising edge where din_valid and din_ready
// are both 1. din_ready is high when idle or while the final bit of the
// current word is on SO, so words can stream with no gap. din_valid while
// din_ready is low is ignored, and din is only looked at on the transfer
// edge.
// ---------------------------------------------------------------------------
module piso_serializer
   import serial_pkg::*;
#(
   parameter int SIZE      = DEFAULT_SIZE,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic            SO,
   output logic            sof,
   output logic            last,
   output logic            busy
);

   localparam int            CW      = $clog2(SIZE);
   localparam logic [CW-1:0] CNT_MAX = CW'(SIZE - 1);
   localparam int            OUT_BIT = MSB_FIRST ? SIZE - 1 : 0;

   state_t          state, state_n;
   logic [SIZE-1:0] sreg, sreg_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            xfer;

   // Output decode
   assign busy      = (state == ST_SHIFT);
   assign sof       = busy && (cnt == CNT_MAX);
   assign last      = busy && (cnt == '0);
   assign din_ready = !rst && ((state == ST_IDLE) || last);
   assign xfer      = din_valid && din_ready;

   // The register is zero-filled as it shifts and cleared on the way back
   // to IDLE, so the output bit can drive SO directly and reads 0 when idle.
   assign SO = sreg[OUT_BIT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sreg  <= sreg_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_n = ST_SHIFT;
               sreg_n  = din;
               cnt_n   = CNT_MAX;
            end
         end
         ST_SHIFT: begin
            if (cnt != '0) begin
               if (MSB_FIRST) sreg_n = {sreg[SIZE-2:0], 1'b0};
               else           sreg_n = {1'b0, sreg[SIZE-1:1]};
               cnt_n = cnt - CW'(1);
            end else if (xfer) begin
               // Final bit on SO and a new word offered: load it now so the
               // next word follows with no idle cycle.
               sreg_n = din;
               cnt_n  = CNT_MAX;
            end else begin
               state_n = ST_IDLE;
               sreg_n  = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Two instances (MSB-first and LSB-first, SIZE=4) share one stimulus
// stream. Accepted words are expanded into per-cycle expected
// {SO, sof, last} entries in one queue per instance; a negedge monitor
// pops and compares.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

   localparam int SIZE = 4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst       = 1'b1;
   logic [SIZE-1:0] din       = '0;
   logic            din_valid = 1'b0;

   logic m_ready, m_so, m_sof, m_last, m_busy;
   logic l_ready, l_so, l_sof, l_last, l_busy;

   piso_serializer #(.SIZE(SIZE), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(m_ready), .SO(m_so), .sof(m_sof), .last(m_last), .busy(m_busy)
   );

   piso_serializer #(.SIZE(SIZE), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(l_ready), .SO(l_so), .sof(l_sof), .last(l_last), .busy(l_busy)
   );

   // scoreboard
   logic [2:0] exp_m_q[$];
   logic [2:0] exp_l_q[$];
   int n_checks = 0;
   int n_errors = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Reference: a word becomes SIZE serial beats; beat i carries bit i of
   // the stream order, sof on beat 0, last on beat SIZE-1.
   task automatic push_word(input logic [SIZE-1:0] w);
      for (int i = 0; i < SIZE; i++) begin
         exp_m_q.push_back({w[SIZE-1-i], i == 0, i == SIZE-1});
         exp_l_q.push_back({w[i],        i == 0, i == SIZE-1});
      end
   endtask

   // monitor: compare mid-cycle, then predict what the coming edge does
   always @(negedge clk) begin
      if (mon_en) begin
         logic       rdy_exp;
         logic [2:0] e;
         // One word is ready to be taken when nothing is queued or only
         // the final beat of the current word is left.
         rdy_exp = !rst && (exp_m_q.size() <= 1);
         chk("msb_din_ready", {2'b0, m_ready}, {2'b0, rdy_exp});
         chk("lsb_din_ready", {2'b0, l_ready}, {2'b0, rdy_exp});
         if (exp_m_q.size() > 0) begin
            e = exp_m_q.pop_front();
            chk("msb_busy", {2'b0, m_busy}, 3'b001);
            chk("msb_beat", {m_so, m_sof, m_last}, e);
         end else begin
            chk("msb_idle", {m_so, m_sof, m_last}, 3'b000);
            chk("msb_busy", {2'b0, m_busy}, 3'b000);
         end
         if (exp_l_q.size() > 0) begin
            e = exp_l_q.pop_front();
            chk("lsb_busy", {2'b0, l_busy}, 3'b001);
            chk("lsb_beat", {l_so, l_sof, l_last}, e);
         end else begin
            chk("lsb_idle", {l_so, l_sof, l_last}, 3'b000);
            chk("lsb_busy", {2'b0, l_busy}, 3'b000);
         end
         if (rst) begin
            exp_m_q.delete();
            exp_l_q.delete();
         end else if (din_valid && rdy_exp) begin
            push_word(din);
         end
      end
   end

   // driver: inputs change just after the rising edge, held for one cycle
   task automatic drive(input logic v, input logic [SIZE-1:0] d, input logic r);
      @(posedge clk);
      #1;
      din_valid = v;
      din       = d;
      rst       = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, SIZE'($urandom_range(0, 15)), 1'b0);
   endtask

   initial begin
      // reset held for two edges, checked while asserted
      @(posedge clk);
      #1 mon_en = 1'b1;
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      idle(2);

      // single word
      drive(1'b1, 4'b1011, 1'b0);
      idle(6);

      // back-to-back words, din_valid held
      drive(1'b1, 4'b1011, 1'b0);
      drive(1'b1, 4'b0110, 1'b0);
      drive(1'b1, 4'b0110, 1'b0);
      drive(1'b1, 4'b0110, 1'b0);
      drive(1'b1, 4'b0110, 1'b0);
      idle(6);

      // din_valid pulsed with zeros in the second bit cycle
      drive(1'b1, 4'b1011, 1'b0);
      drive(1'b0, 4'b1111, 1'b0);
      drive(1'b1, 4'b0000, 1'b0);
      idle(5);

      // reset after two bits have gone out
      drive(1'b1, 4'b1011, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      drive(1'b0, 4'b0000, 1'b1);
      idle(3);

      // reset on the same edge as a transfer
      drive(1'b1, 4'b1111, 1'b1);
      idle(3);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, SIZE'($urandom_range(0, 15)),
               $urandom_range(0, 39) == 0);
      idle(8);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
